// File: rtl/media_pkg.sv
// Shared types, mode codes and width helpers for the block downscaler.
package media_pkg;

  typedef enum logic [2:0] {
    IDLE, SETUP, LER, DRENAR, DIVIDIR, ESCREVER, FIM
  } state_t;

  localparam logic [1:0] MODO_MEDIA = 2'b00;
  localparam logic [1:0] MODO_DECIM = 2'b01;
  localparam logic [1:0] MODO_MAX   = 2'b10;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int sum_w(input int pix_w, input int max_f);
    return pix_w + 2 * clog2(max_f);
  endfunction

  localparam int SUM_W = sum_w(8, 8);

  // Exponent of a power-of-two factor.
  function automatic logic [3:0] log2f(input logic [3:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (v[i]) r = 4'(i);
    return r;
  endfunction

endpackage

// File: rtl/media_blocos_param_if.sv
// Control, source-read and frame-write signals of the block downscaler.
interface media_blocos_param_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 19
);
  logic              start;
  logic [3:0]        fator;
  logic [1:0]        modo;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, fator, modo, rd_data,
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  busy, done, err
  );

  modport slave (
    input  start, fator, modo, rd_data,
    output rd_addr, wr_en, wr_addr, wr_data,
    output busy, done, err
  );
endinterface

// File: rtl/media_div_seq.sv
// Restoring divider, one quotient bit per cycle, SUM_W cycles per divide.
module media_div_seq #(
  parameter int SUM_W = 14,
  parameter int QW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [7:0]       divisor,
  output logic [QW-1:0]    quotient,
  output logic             done
);
  localparam int CNT_W = $clog2(SUM_W) + 1;

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       rem;
  logic [SUM_W-1:0] q;
  logic [7:0]       cur_rem;
  logic [SUM_W-1:0] cur_q;
  logic [8:0]       rem_sh;
  logic             ge;
  logic [7:0]       nxt_rem;

  always_comb begin
    cur_rem = active ? rem : '0;
    cur_q   = active ? q : dividend;
    rem_sh  = {cur_rem, cur_q[SUM_W-1]};
    ge      = rem_sh >= {1'b0, divisor};
    nxt_rem = ge ? 8'(rem_sh - {1'b0, divisor})
                 : rem_sh[7:0];
  end

  // First step happens in the start cycle itself.
  assign done     = active && (cnt == CNT_W'(SUM_W - 1));
  assign quotient = q[QW-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      cnt    <= '0;
      rem    <= '0;
      q      <= '0;
    end else if (active || start) begin
      rem <= nxt_rem;
      q   <= {cur_q[SUM_W-2:0], ge};
      if (!active) begin
        active <= 1'b1;
        cnt    <= CNT_W'(1);
      end else if (done) begin
        active <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/media_blocos_param.sv
// Block downscaler: mean/decimate/max over f x f blocks into a frame RAM.
// Define MEDIA_ROUND_EN for round-to-nearest mean instead of floor.
module media_blocos_param
  import media_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int SRC_W     = 160,
  parameter int SRC_H     = 120,
  parameter int ADDR_W    = 19,
  parameter int MAX_FATOR = 8,
  parameter int RD_LAT    = 1
) (
  input logic                clk,
  input logic                reset,
  media_blocos_param_if.slave bus
);
  localparam int ACC_W = sum_w(PIX_W, MAX_FATOR);
  localparam int DIM   = (SRC_W > SRC_H) ? SRC_W : SRC_H;
  localparam int CW    = clog2(DIM + 1);

  state_t state, nxt;

  logic [3:0]        f;
  logic [1:0]        modo;
  logic              err_q;
  logic [CW-1:0]     rem_w, rem_h;
  logic [CW-1:0]     dst_w, dst_h;
  logic [CW-1:0]     bx, by;
  logic [3:0]        sx, sy;
  logic [ADDR_W-1:0] row_base, blk_base;
  logic [ADDR_W-1:0] line_addr, dst_addr;
  logic [ACC_W-1:0]  acc;
  logic [RD_LAT-1:0] vpipe;
  logic [1:0]        drain;

  logic              ok_f, step_w, step_h;
  logic              last_rd, last_x, last_y;
  logic              pow2, div_start, div_done;
  logic [7:0]        nn;
  logic [4:0]        sh;
  logic [ACC_W-1:0]  sum_adj;
  logic [PIX_W-1:0]  q_div, res;
  logic [ADDR_W-1:0] row_step;

  assign ok_f = (bus.fator != 4'd0) &&
                (int'(bus.fator) <= MAX_FATOR);
  assign step_w  = rem_w >= CW'(f);
  assign step_h  = rem_h >= CW'(f);
  assign last_rd = (modo == MODO_DECIM) ||
                   (sx == f - 4'd1 && sy == f - 4'd1);
  assign last_x  = bx == dst_w - CW'(1);
  assign last_y  = by == dst_h - CW'(1);
  assign pow2    = (f & (f - 4'd1)) == 4'd0;
  assign nn      = 8'(f) * 8'(f);
  assign sh      = {log2f(f), 1'b0};
  assign row_step = ADDR_W'(f) * ADDR_W'(SRC_W);

`ifdef MEDIA_ROUND_EN
  assign sum_adj = acc + ACC_W'(nn >> 1);
`else
  assign sum_adj = acc;
`endif

  assign div_start = state == DIVIDIR;

  media_div_seq #(
    .SUM_W (ACC_W),
    .QW    (PIX_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (sum_adj),
    .divisor  (nn),
    .quotient (q_div),
    .done     (div_done)
  );

  always_comb begin
    res = PIX_W'(acc);
    if (modo == MODO_MEDIA)
      res = pow2 ? PIX_W'(sum_adj >> sh) : q_div;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, FIM:
        if (bus.start) nxt = ok_f ? SETUP : FIM;
      SETUP:
        if (!step_w && !step_h)
          nxt = (dst_w == '0 || dst_h == '0) ? FIM : LER;
      LER:
        if (last_rd) nxt = DRENAR;
      DRENAR:
        if (drain == 2'd0)
          nxt = (modo == MODO_MEDIA && !pow2)
                ? DIVIDIR : ESCREVER;
      DIVIDIR:
        if (div_done) nxt = ESCREVER;
      ESCREVER:
        nxt = (last_x && last_y) ? FIM : LER;
      default:
        nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f         <= '0;
      modo      <= MODO_MEDIA;
      err_q     <= 1'b0;
      rem_w     <= '0;
      rem_h     <= '0;
      dst_w     <= '0;
      dst_h     <= '0;
      bx        <= '0;
      by        <= '0;
      sx        <= '0;
      sy        <= '0;
      row_base  <= '0;
      blk_base  <= '0;
      line_addr <= '0;
      dst_addr  <= '0;
      acc       <= '0;
      vpipe     <= '0;
      drain     <= '0;
    end else begin
      vpipe <= (vpipe << 1) | RD_LAT'(state == LER);
      // Tag marks the cycle a requested sample is on rd_data.
      if (vpipe[RD_LAT-1]) begin
        unique case (modo)
          MODO_DECIM: acc <= ACC_W'(bus.rd_data);
          MODO_MAX:
            if (ACC_W'(bus.rd_data) > acc)
              acc <= ACC_W'(bus.rd_data);
          default: acc <= acc + ACC_W'(bus.rd_data);
        endcase
      end
      unique case (state)
        IDLE, FIM:
          if (bus.start) begin
            f         <= bus.fator;
            modo      <= (bus.modo == 2'b11)
                         ? MODO_MEDIA : bus.modo;
            err_q     <= !ok_f;
            rem_w     <= CW'(SRC_W);
            rem_h     <= CW'(SRC_H);
            dst_w     <= '0;
            dst_h     <= '0;
            bx        <= '0;
            by        <= '0;
            sx        <= '0;
            sy        <= '0;
            row_base  <= '0;
            blk_base  <= '0;
            line_addr <= '0;
            dst_addr  <= '0;
            acc       <= '0;
          end
        SETUP: begin
          if (step_w) begin
            rem_w <= rem_w - CW'(f);
            dst_w <= dst_w + CW'(1);
          end
          if (step_h) begin
            rem_h <= rem_h - CW'(f);
            dst_h <= dst_h + CW'(1);
          end
        end
        LER:
          if (last_rd) begin
            drain <= 2'(RD_LAT - 1);
          end else if (sx == f - 4'd1) begin
            sx        <= '0;
            sy        <= sy + 4'd1;
            line_addr <= line_addr + ADDR_W'(SRC_W);
          end else begin
            sx <= sx + 4'd1;
          end
        DRENAR:
          if (drain != 2'd0) drain <= drain - 2'd1;
        ESCREVER: begin
          dst_addr <= dst_addr + ADDR_W'(1);
          sx       <= '0;
          sy       <= '0;
          acc      <= '0;
          if (last_x) begin
            bx        <= '0;
            by        <= by + CW'(1);
            row_base  <= row_base + row_step;
            blk_base  <= row_base + row_step;
            line_addr <= row_base + row_step;
          end else begin
            bx        <= bx + CW'(1);
            blk_base  <= blk_base + ADDR_W'(f);
            line_addr <= blk_base + ADDR_W'(f);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_addr = line_addr + ADDR_W'(sx);
  assign bus.wr_en   = state == ESCREVER;
  assign bus.wr_addr = bus.wr_en ? dst_addr : '0;
  assign bus.wr_data = bus.wr_en ? res : '0;
  assign bus.busy    = !(state == IDLE || state == FIM);
  assign bus.done    = state == FIM;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_media_blocos_param.sv
// Bench: two downscalers (read latency 1 and 3) against a block-reduction model.
module tb_media_blocos_param;
  localparam int SW    = 22;
  localparam int SH    = 15;
  localparam int NPIX  = SW * SH;
  localparam int LOGN  = 8192;
  localparam int LIMIT = 5000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] fator;
  logic [1:0] modo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] img [0:NPIX-1];
  logic [7:0] pa, pb0, pb1, pb2;
  logic [7:0] exp_d [$];

  logic [18:0] wl_addr [2][LOGN];
  logic [7:0]  wl_data [2][LOGN];
  int          wl_cyc  [2][LOGN];
  int          wn [2] = '{0, 0};
  int          last_base [2];

  media_blocos_param_if #(.PIX_W(8), .ADDR_W(19)) bus_a ();
  media_blocos_param_if #(.PIX_W(8), .ADDR_W(19)) bus_b ();

  media_blocos_param #(
    .PIX_W(8), .SRC_W(SW), .SRC_H(SH), .ADDR_W(19),
    .MAX_FATOR(8), .RD_LAT(1)
  ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  media_blocos_param #(
    .PIX_W(8), .SRC_W(SW), .SRC_H(SH), .ADDR_W(19),
    .MAX_FATOR(8), .RD_LAT(3)
  ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;

  assign bus_a.start   = start;
  assign bus_a.fator   = fator;
  assign bus_a.modo    = modo;
  assign bus_b.start   = start;
  assign bus_b.fator   = fator;
  assign bus_b.modo    = modo;
  assign bus_a.rd_data = pa;
  assign bus_b.rd_data = pb2;

  logic [1:0] busy_v, done_v, err_v, wen_v;
  assign busy_v = {bus_b.busy, bus_a.busy};
  assign done_v = {bus_b.done, bus_a.done};
  assign err_v  = {bus_b.err, bus_a.err};
  assign wen_v  = {bus_b.wr_en, bus_a.wr_en};

  function automatic logic [7:0] rd(input logic [18:0] a);
    return (int'(a) < NPIX) ? img[int'(a)] : 8'd0;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pa  <= rd(bus_a.rd_addr);
    pb0 <= rd(bus_b.rd_addr);
    pb1 <= pb0;
    pb2 <= pb1;
  end

  always @(negedge clk) begin
    if (bus_a.wr_en && wn[0] < LOGN) begin
      wl_addr[0][wn[0]] <= bus_a.wr_addr;
      wl_data[0][wn[0]] <= bus_a.wr_data;
      wl_cyc[0][wn[0]]  <= cyc;
      wn[0] <= wn[0] + 1;
    end
    if (bus_b.wr_en && wn[1] < LOGN) begin
      wl_addr[1][wn[1]] <= bus_b.wr_addr;
      wl_data[1][wn[1]] <= bus_b.wr_data;
      wl_cyc[1][wn[1]]  <= cyc;
      wn[1] <= wn[1] + 1;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Reference: reduce every whole f x f block of img, row-major.
  task automatic model(input int f, input int mo);
    int s, mx, p, n, v;
    exp_d.delete();
    n = f * f;
    for (int by = 0; by < SH / f; by++)
      for (int bx = 0; bx < SW / f; bx++) begin
        s = 0;
        mx = 0;
        for (int sy = 0; sy < f; sy++)
          for (int sx = 0; sx < f; sx++) begin
            p = int'(img[(by*f+sy)*SW + bx*f+sx]);
            s += p;
            if (p > mx) mx = p;
          end
        if (mo == 1)      v = int'(img[by*f*SW + bx*f]);
        else if (mo == 2) v = mx;
`ifdef MEDIA_ROUND_EN
        else              v = (s + n / 2) / n;
`else
        else              v = s / n;
`endif
        exp_d.push_back(8'(v));
      end
  endtask

  // Cycles between consecutive writes: reads + latency + divide + write.
  function automatic int pix_lat(input int f, input int mo,
                                 input int lat);
    int r, d;
    r = (mo == 1) ? 1 : f * f;
    d = 0;
    if ((mo == 0 || mo == 3) &&
        !(f == 1 || f == 2 || f == 4 || f == 8))
      d = 8 + 2 * 3;
    return r + lat + d + 1;
  endfunction

  task automatic run(input int f, input int mo, input bit poke);
    bit valid;
    int n, cnt, lat;
    valid = (f >= 1 && f <= 8);
    if (valid) model(f, mo);
    else exp_d.delete();
    last_base[0] = wn[0];
    last_base[1] = wn[1];
    @(negedge clk);
    fator = 4'(f);
    modo  = 2'(mo);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("busy_after_start", 32'(busy_v[k]), 32'(valid));
      check("err_after_start", 32'(err_v[k]), 32'(!valid));
      check("done_after_start", 32'(done_v[k]), 32'(!valid));
    end
    if (poke) begin
      repeat (6) @(negedge clk);
      fator = 4'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      fator = 4'(f);
    end
    n = 0;
    while (done_v != 2'b11 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("timeout", 32'(n < LIMIT), 32'd1);
    repeat (8) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? 1 : 3;
      cnt = wn[k] - last_base[k];
      check("fin_done", 32'(done_v[k]), 32'd1);
      check("fin_busy", 32'(busy_v[k]), 32'd0);
      check("fin_err", 32'(err_v[k]), 32'(!valid));
      check("n_writes", 32'(cnt), 32'(exp_d.size()));
      for (int i = 0; i < cnt && i < exp_d.size(); i++) begin
        check("wr_addr", 32'(wl_addr[k][last_base[k]+i]),
              32'(i));
        check("wr_data", 32'(wl_data[k][last_base[k]+i]),
              32'(exp_d[i]));
      end
      if (valid && cnt >= 2)
        check("pix_interval",
              32'(wl_cyc[k][last_base[k]+1] -
                  wl_cyc[k][last_base[k]]),
              32'(pix_lat(f, mo, lat)));
    end
  endtask

  initial begin
    int b0, b1, f, mo;
    reset = 1'b0;
    start = 1'b0;
    fator = 4'd0;
    modo  = 2'd0;
    for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", 32'(busy_v[k]), 32'd0);
      check("rst_done", 32'(done_v[k]), 32'd0);
      check("rst_err", 32'(err_v[k]), 32'd0);
      check("rst_wr_en", 32'(wen_v[k]), 32'd0);
    end
    check("rst_rd_addr", 32'(bus_a.rd_addr), 32'd0);
    reset = 1'b1;

    // Ramp pix=x, f=2 mean, with an ignored start mid-frame.
    for (int i = 0; i < NPIX; i++) img[i] = 8'(i % SW);
    run(2, 0, 1'b1);
    for (int k = 0; k < 2; k++)
`ifdef MEDIA_ROUND_EN
      check("ramp_k3", 32'(wl_data[k][last_base[k]+3]), 32'd7);
`else
      check("ramp_k3", 32'(wl_data[k][last_base[k]+3]), 32'd6);
`endif

    // All-255, f=3 mean through the divider.
    for (int i = 0; i < NPIX; i++) img[i] = 8'd255;
    run(3, 0, 1'b0);
    for (int k = 0; k < 2; k++)
      check("ones_last",
            32'(wl_data[k][last_base[k]+exp_d.size()-1]),
            32'd255);

    // Block {10,11,12,13}, f=2 mean.
    for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
    img[0]      = 8'd10;
    img[1]      = 8'd11;
    img[SW]     = 8'd12;
    img[SW + 1] = 8'd13;
    run(2, 0, 1'b0);
    for (int k = 0; k < 2; k++)
`ifdef MEDIA_ROUND_EN
      check("blk_mean", 32'(wl_data[k][last_base[k]]), 32'd12);
`else
      check("blk_mean", 32'(wl_data[k][last_base[k]]), 32'd11);
`endif

    // f=4 max with one bright pixel in block 0.
    for (int i = 0; i < NPIX; i++) img[i] = 8'd7;
    img[SW + 2] = 8'd200;
    run(4, 2, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check("max_blk0", 32'(wl_data[k][last_base[k]]), 32'd200);
      check("max_blk1", 32'(wl_data[k][last_base[k]+1]), 32'd7);
    end

    // Rejected factors.
    run(0, 0, 1'b0);
    run(9, 1, 1'b0);

    // Randomised frames.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
      f  = int'($urandom_range(1, 8));
      mo = int'($urandom_range(0, 3));
      run(f, mo, 1'b0);
    end

    // Reset in the middle of a frame.
    @(negedge clk);
    fator = 4'd2;
    modo  = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("mid_rst_busy", 32'(busy_v[k]), 32'd0);
      check("mid_rst_done", 32'(done_v[k]), 32'd0);
      check("mid_rst_wr_en", 32'(wen_v[k]), 32'd0);
    end
    check("mid_rst_rd_addr_a", 32'(bus_a.rd_addr), 32'd0);
    check("mid_rst_rd_addr_b", 32'(bus_b.rd_addr), 32'd0);
    check("mid_rst_wr_addr", 32'(bus_b.wr_addr), 32'd0);
    check("mid_rst_wr_data", 32'(bus_b.wr_data), 32'd0);
    b0 = wn[0];
    b1 = wn[1];
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_wr_a", 32'(wn[0] - b0), 32'd0);
    check("post_rst_wr_b", 32'(wn[1] - b1), 32'd0);
    check("post_rst_busy", 32'(busy_v), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
